ahb_ext_sram: RTL and testbench
===============================

AHB_EXT_SRAM -- requirements
Module: ahb_ext_sram

Purpose: AHB-Lite subordinate that responds to the core's 32-bit AHB initiator. It maps the external-memory window onto the board's asynchronous 16-bit SRAM, serving each word as two halfword accesses.

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 20, giving the SRAM halfword address width.
REQ-002 SHALL have parameter SRAM_WAIT, default 1, range 1..7, giving the extra cycles per halfword access.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port HCLK, input, 1 bit: clock.
REQ-005 SHALL have port HRESETn, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port HSEL, input, 1 bit: subordinate select.
REQ-007 SHALL have port HADDR, input, 32 bits: byte address.
REQ-008 SHALL have port HWRITE, input, 1 bit: 1 = write.
REQ-009 SHALL have port HTRANS, input, 2 bits: IDLE, BUSY, NONSEQ or SEQ.
REQ-010 SHALL have port HSIZE, input, 3 bits: transfer size.
REQ-011 SHALL have port HBURST, input, 3 bits: burst type.
REQ-012 SHALL have port HWDATA, input, 32 bits: write data, valid in the first data-phase cycle.
REQ-013 SHALL have port HWSTRB, input, 4 bits: byte strobes, sampled with HWDATA.
REQ-014 SHALL have port HREADY, input, 1 bit: bus-wide ready.
REQ-015 SHALL have port HREADYOUT, output, 1 bit: this subordinate is ready.
REQ-016 SHALL have port HRESP, output, 1 bit: 1 = ERROR.
REQ-017 SHALL have port HRDATA, output, 32 bits: read data.
REQ-018 SHALL have port SRAM_ADDR, output, ADDR_BITS bits: halfword address.
REQ-019 SHALL have port SRAM_DQ_O, output, 16 bits: write data to the pad.
REQ-020 SHALL have port SRAM_DQ_OE, output, 1 bit: pad output enable.
REQ-021 SHALL have port SRAM_DQ_I, input, 16 bits: read data from the pad.
REQ-022 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N and SRAM_LB_N, each output, 1 bit, all active-low strobes.

Function
REQ-023 SHALL capture an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1.
REQ-024 SHALL treat SEQ like NONSEQ, and SHALL treat HBURST as informational only.
REQ-025 SHALL give IDLE and BUSY transfers a zero-wait OKAY response.
REQ-026 SHALL register HADDR[ADDR_BITS:1] with bit 0 forced to 0 as the low halfword address; the high halfword address is the same value with bit 0 = 1.
REQ-027 SHALL implement FSM states IDLE, WCAP, LO, HI, RESP, ERR1 and ERR2.
REQ-028 SHALL transition IDLE -> ERR1 on a captured transfer with HSIZE > 3'b010.
REQ-029 SHALL transition IDLE -> LO on a captured read.
REQ-030 SHALL transition IDLE -> WCAP on a captured write.
REQ-031 In WCAP (exactly 1 cycle), SHALL latch HWDATA and HWSTRB.
- Next state is LO if HWSTRB[1:0] != 0.
- Otherwise HI if HWSTRB[3:2] != 0.
- Otherwise RESP.
REQ-032 SHALL make LO and HI last SRAM_WAIT+1 cycles each, timed by a 3-bit counter.
- LO -> HI, except a write with HWSTRB[3:2]=0 goes LO -> RESP.
- HI -> RESP.
REQ-033 During a read halfword, SHALL hold CE_N=0, OE_N=0, UB_N=0 and LB_N=0, and SHALL sample SRAM_DQ_I on the last cycle into HRDATA[15:0] (LO) or HRDATA[31:16] (HI).
REQ-034 During a write halfword, SHALL hold CE_N=0, OE_N=1 and DQ_OE=1 for all cycles.
- WE_N=0 for the first SRAM_WAIT cycles and 1 in the last cycle.
- Address and data are held stable throughout.
- UB_N/LB_N = inverted strobe bits [1]/[0] (LO) or [3]/[2] (HI).
REQ-035 SHALL register all SRAM-side outputs, so that no combinational path runs from AHB inputs to the pads.
REQ-036 SHALL hold HREADYOUT=0 in WCAP, LO, HI and ERR1.
REQ-037 SHALL drive HREADYOUT=1 in IDLE, RESP and ERR2.
REQ-038 In RESP (1 cycle), SHALL drive HRESP=0 with HRDATA valid for reads.
- A new address phase may be captured in the same cycle, with no gap.
- Otherwise the FSM returns to IDLE.
REQ-039 SHALL implement the error response as ERR1 (HRESP=1, HREADYOUT=0) -> ERR2 (HRESP=1, HREADYOUT=1) -> IDLE, with no SRAM strobe asserted.
REQ-040 Outside accesses, SHALL hold CE_N, OE_N, WE_N, UB_N and LB_N at 1 and DQ_OE at 0; HRDATA SHALL hold its last value.
REQ-041 With SRAM_WAIT=1, latency SHALL be:
- Read: 5 data-phase cycles.
- Full-word write: 6 data-phase cycles.
- Single-half write: 4 data-phase cycles.

Reset
REQ-042 SHALL, on a clock edge with HRESETn=0, set state to IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, SRAM_ADDR=0, SRAM_DQ_O=0, DQ_OE=0, all SRAM strobes to 1, and the counter to 0.
REQ-043 SHALL abort any in-flight access on reset, with WE_N=1 by the first reset edge; no completion is signalled.

Verification
REQ-044 Reset: hold HRESETn=0 for 2 cycles mid-write -> after the first edge WE_N=1, CE_N=1, DQ_OE=0, HREADYOUT=1 and state IDLE.
REQ-045 Word write: 0xDEADBEEF to 0x20000010, HWSTRB=1111, SRAM_WAIT=1 -> 0xBEEF at SRAM_ADDR 0x00008, then 0xDEAD at 0x00009; one WE_N-low cycle each; HREADYOUT=1 in data-phase cycle 6.
REQ-046 Word read: read back 0x20000010 -> HRDATA=0xDEADBEEF with HREADYOUT=1 in data-phase cycle 5; OE_N=0 and WE_N=1 throughout.
REQ-047 Byte write: 0x00AA0000 to 0x20000012, HWSTRB=0100 -> HI phase only, SRAM_ADDR 0x00009, DQ_O=0x00AA, UB_N=1, LB_N=0; done in cycle 4.
REQ-048 Unsupported size: HSIZE=3'b011 -> ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1); CE_N stays 1.
REQ-049 Burst: INCR4 read burst from 0x20000000 -> 4 beats of 5 cycles each; each next address is captured in the RESP cycle; the 4 HRDATA values match preloaded SRAM contents.

Source files
------------

// File: rtl/ahb_ext_sram.sv
// AHB-Lite subordinate bridging 32-bit transfers onto an asynchronous 16-bit SRAM.
// Each word is served as a low then a high halfword access; all pad signals are registered.
`timescale 1ns/1ps
module ahb_ext_sram #(
    parameter int unsigned ADDR_BITS = 20,
    parameter int unsigned SRAM_WAIT = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [31:0]          HWDATA,
    input  logic [3:0]           HWSTRB,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [ADDR_BITS-1:0] SRAM_ADDR,
    output logic [15:0]          SRAM_DQ_O,
    output logic                 SRAM_DQ_OE,
    input  logic [15:0]          SRAM_DQ_I,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WCAP = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
        RESP = 3'd4,
        ERR1 = 3'd5,
        ERR2 = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             strb_q, strb_d;
    logic                   hreadyout_q, hreadyout_d;
    logic                   hresp_q, hresp_d;
    logic [31:0]            hrdata_q, hrdata_d;
    logic [ADDR_BITS-1:0]   sram_addr_q, sram_addr_d;
    logic [15:0]            dq_o_q, dq_o_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   ub_n_q, ub_n_d;
    logic                   lb_n_q, lb_n_d;

    logic capture;
    logic access;
    logic hi_half;

    assign capture = HSEL && HREADY && HTRANS[1];

    // Bus fields that carry no meaning for this memory window.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0], HADDR[31:ADDR_BITS+1], HADDR[1:0]};

    // Sequencing of the halfword accesses and read-data capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        hrdata_d = hrdata_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (capture) begin
                    addr_d  = {HADDR[ADDR_BITS:2], 1'b0};
                    write_d = HWRITE;
                    if (HSIZE > 3'b010) begin
                        state_d = ERR1;
                    end else if (HWRITE) begin
                        state_d = WCAP;
                    end else begin
                        state_d = LO;
                    end
                end
            end
            WCAP: begin
                wdata_d = HWDATA;
                strb_d  = HWSTRB;
                if (HWSTRB[1:0] != 2'b00) begin
                    state_d = LO;
                end else if (HWSTRB[3:2] != 2'b00) begin
                    state_d = HI;
                end else begin
                    state_d = RESP;
                end
            end
            LO: begin
                if (cnt_q == CNT_LAST) begin
                    if (!write_q) begin
                        hrdata_d[15:0] = SRAM_DQ_I;
                    end
                    if (write_q && (strb_q[3:2] == 2'b00)) begin
                        state_d = RESP;
                    end else begin
                        state_d = HI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (cnt_q == CNT_LAST) begin
                    if (!write_q) begin
                        hrdata_d[31:16] = SRAM_DQ_I;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR1:    state_d = ERR2;
            ERR2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pad and response values for the coming cycle, derived from the next state.
    always_comb begin
        access      = (state_d == LO) || (state_d == HI);
        hi_half     = (state_d == HI);
        ce_n_d      = !access;
        oe_n_d      = !(access && !write_d);
        dq_oe_d     = access && write_d;
        we_n_d      = !(access && write_d && (cnt_d < CNT_LAST));
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        if (access) begin
            sram_addr_d = {addr_d[ADDR_BITS-1:1], hi_half};
            if (write_d) begin
                ub_n_d = hi_half ? !strb_d[3] : !strb_d[1];
                lb_n_d = hi_half ? !strb_d[2] : !strb_d[0];
                dq_o_d = hi_half ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
            end
        end
        hreadyout_d = (state_d == IDLE) || (state_d == RESP) || (state_d == ERR2);
        hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
        end
    end

    assign HREADYOUT  = hreadyout_q;
    assign HRESP      = hresp_q;
    assign HRDATA     = hrdata_q;
    assign SRAM_ADDR  = sram_addr_q;
    assign SRAM_DQ_O  = dq_o_q;
    assign SRAM_DQ_OE = dq_oe_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_UB_N  = ub_n_q;
    assign SRAM_LB_N  = lb_n_q;

endmodule

// File: tb/tb_ahb_ext_sram.sv
// Bench for ahb_ext_sram: AHB driver, SRAM model and two scoreboards
// (bus responses and SRAM write cycles) with hand-computed expectations.
`timescale 1ns/1ps
module tb_ahb_ext_sram;

    localparam int unsigned ADDR_BITS = 20;
    localparam int unsigned SRAM_WAIT = 1;

    logic                 HCLK;
    logic                 HRESETn;
    logic                 HSEL;
    logic [31:0]          HADDR;
    logic                 HWRITE;
    logic [1:0]           HTRANS;
    logic [2:0]           HSIZE;
    logic [2:0]           HBURST;
    logic [31:0]          HWDATA;
    logic [3:0]           HWSTRB;
    logic                 HREADY;
    logic                 HREADYOUT;
    logic                 HRESP;
    logic [31:0]          HRDATA;
    logic [ADDR_BITS-1:0] SRAM_ADDR;
    logic [15:0]          SRAM_DQ_O;
    logic                 SRAM_DQ_OE;
    logic [15:0]          SRAM_DQ_I;
    logic                 SRAM_CE_N;
    logic                 SRAM_OE_N;
    logic                 SRAM_WE_N;
    logic                 SRAM_UB_N;
    logic                 SRAM_LB_N;

    assign HREADY = HREADYOUT;

    ahb_ext_sram #(.ADDR_BITS(ADDR_BITS), .SRAM_WAIT(SRAM_WAIT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE),
        .SRAM_DQ_I(SRAM_DQ_I), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] rdata;
        int          lat;
        int          ce;
        int          we;
        int          oe;
        int          id;
    } exp_t;

    typedef struct {
        logic [ADDR_BITS-1:0] addr;
        logic [15:0]          data;
        logic                 ub_n;
        logic                 lb_n;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;
    logic preload;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic err, input logic rd, input logic [31:0] rdata,
                            input int lat, input int ce, input int we, input int oe);
        exp_t e;
        e.err = err; e.rd = rd; e.rdata = rdata;
        e.lat = lat; e.ce = ce; e.we = we; e.oe = oe; e.id = next_id;
        next_id++;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [ADDR_BITS-1:0] a, input logic [15:0] d,
                           input logic ub_n, input logic lb_n);
        wr_t w;
        w.addr = a; w.data = d; w.ub_n = ub_n; w.lb_n = lb_n;
        wr_q.push_back(w);
    endtask

    // SRAM model: preload during the first reset, write on a WE_N-low sample.
    logic [15:0] mem [0:255];
    wr_t         w_cur;
    assign SRAM_DQ_I = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;

    always @(negedge HCLK) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        end else if (!SRAM_CE_N && !SRAM_WE_N) begin
            check("write_dq_oe", 32'(SRAM_DQ_OE), 32'd1);
            check("write_oe_n", 32'(SRAM_OE_N), 32'd1);
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL sram_write: unexpected write at %h data %h, required none", SRAM_ADDR, SRAM_DQ_O);
            end else begin
                w_cur = wr_q.pop_front();
                check("sram_wr_addr", 32'(SRAM_ADDR), 32'(w_cur.addr));
                check("sram_wr_data", 32'(SRAM_DQ_O), 32'(w_cur.data));
                check("sram_wr_ub_n", 32'(SRAM_UB_N), 32'(w_cur.ub_n));
                check("sram_wr_lb_n", 32'(SRAM_LB_N), 32'(w_cur.lb_n));
            end
            if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  = SRAM_DQ_O[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] = SRAM_DQ_O[15:8];
        end
    end

    // Response monitor: tracks data phases, pops and compares on completion.
    logic dph;
    int   dcyc, ce_cnt, we_cnt, oe_cnt;
    exp_t e_cur;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dph = 1'b0;
            exp_q.delete();
        end else begin
            if (dph) begin
                dcyc++;
                if (!SRAM_CE_N) ce_cnt++;
                if (!SRAM_WE_N) we_cnt++;
                if (!SRAM_OE_N) oe_cnt++;
                if (exp_q.size() != 0 && exp_q[0].err && dcyc == 1) begin
                    check($sformatf("t%0d_err1_hresp", exp_q[0].id), 32'(HRESP), 32'd1);
                    check($sformatf("t%0d_err1_hreadyout", exp_q[0].id), 32'(HREADYOUT), 32'd0);
                end
                if (HREADYOUT) begin
                    dph = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL response: unexpected completion after %0d cycles, required none", dcyc);
                    end else begin
                        e_cur = exp_q.pop_front();
                        check($sformatf("t%0d_hresp", e_cur.id), 32'(HRESP), 32'(e_cur.err));
                        if (e_cur.rd) check($sformatf("t%0d_hrdata", e_cur.id), HRDATA, e_cur.rdata);
                        check($sformatf("t%0d_latency", e_cur.id), 32'(dcyc), 32'(e_cur.lat));
                        check($sformatf("t%0d_ce_cycles", e_cur.id), 32'(ce_cnt), 32'(e_cur.ce));
                        check($sformatf("t%0d_we_cycles", e_cur.id), 32'(we_cnt), 32'(e_cur.we));
                        check($sformatf("t%0d_oe_cycles", e_cur.id), 32'(oe_cnt), 32'(e_cur.oe));
                    end
                end
            end
            if (HREADYOUT && HSEL && HTRANS[1]) begin
                dph = 1'b1;
                dcyc = 0; ce_cnt = 0; we_cnt = 0; oe_cnt = 0;
            end
        end
    end

    // One AHB address phase; returns at the start of its first data-phase cycle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic [31:0] wd, input logic [3:0] st);
        int n;
        HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = tr; HBURST = bu;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!HREADYOUT && n < 50);
        checks++;
        if (!HREADYOUT) begin
            errors++;
            $display("FAIL addr_accept: HREADYOUT low for %0d cycles, required 1", n);
        end
        @(posedge HCLK); #1;
        HWDATA = wd; HWSTRB = st;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses and %0d writes outstanding, required 0",
                     exp_q.size(), wr_q.size());
        end
        @(posedge HCLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; preload = 1'b1;
        HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010;
        HBURST = 3'b000; HWDATA = '0; HWSTRB = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_sram_addr", 32'(SRAM_ADDR), 32'h0);
        check("rst_dq_o", 32'(SRAM_DQ_O), 32'h0);
        check("rst_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
        check("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        HRESETn = 1'b1; preload = 1'b0;

        // BUSY and IDLE while selected: zero-wait, no SRAM activity
        HSEL = 1'b1; HTRANS = 2'b01;
        @(posedge HCLK); #1;
        check("busy_hreadyout", 32'(HREADYOUT), 32'd1);
        check("busy_ce_n", 32'(SRAM_CE_N), 32'd1);
        HTRANS = 2'b00;
        @(posedge HCLK); #1;
        check("idle_hreadyout", 32'(HREADYOUT), 32'd1);
        check("idle_hresp", 32'(HRESP), 32'd0);
        HSEL = 1'b0;

        // Reset in the middle of a write, while WE_N is low on the low halfword
        push_wr(20'h00010, 16'h5678, 1'b0, 1'b0);
        xfer(32'h2000_0020, 1'b1, 3'b010, 2'b10, 3'b000, 32'h1234_5678, 4'hF);
        @(posedge HCLK); #1;
        check("midwr_we_n_low", 32'(SRAM_WE_N), 32'd0);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        check("midwr_rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("midwr_rst_ce_n", 32'(SRAM_CE_N), 32'd1);
        check("midwr_rst_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
        check("midwr_rst_hreadyout", 32'(HREADYOUT), 32'd1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        drain();

        // Full-word write
        push_exp(1'b0, 1'b0, 32'h0, 6, 4, 2, 0);
        push_wr(20'h00008, 16'hBEEF, 1'b0, 1'b0);
        push_wr(20'h00009, 16'hDEAD, 1'b0, 1'b0);
        xfer(32'h2000_0010, 1'b1, 3'b010, 2'b10, 3'b000, 32'hDEAD_BEEF, 4'hF);
        drain();

        // Word read-back
        push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, 5, 4, 0, 4);
        xfer(32'h2000_0010, 1'b0, 3'b010, 2'b10, 3'b000, 32'h0, 4'h0);
        drain();

        // Byte write on the high halfword only
        push_exp(1'b0, 1'b0, 32'h0, 4, 2, 1, 0);
        push_wr(20'h00009, 16'h00AA, 1'b1, 1'b0);
        xfer(32'h2000_0012, 1'b1, 3'b000, 2'b10, 3'b000, 32'h00AA_0000, 4'b0100);
        drain();

        push_exp(1'b0, 1'b1, 32'hDEAA_BEEF, 5, 4, 0, 4);
        xfer(32'h2000_0010, 1'b0, 3'b010, 2'b10, 3'b000, 32'h0, 4'h0);
        drain();

        // Unsupported size: two-cycle error, no strobes
        push_exp(1'b1, 1'b0, 32'h0, 2, 0, 0, 0);
        xfer(32'h2000_0010, 1'b0, 3'b011, 2'b10, 3'b000, 32'h0, 4'h0);
        drain();

        // INCR4 read burst over preloaded contents, beats pipelined into RESP
        push_exp(1'b0, 1'b1, 32'hA001_A000, 5, 4, 0, 4);
        push_exp(1'b0, 1'b1, 32'hA003_A002, 5, 4, 0, 4);
        push_exp(1'b0, 1'b1, 32'hA005_A004, 5, 4, 0, 4);
        push_exp(1'b0, 1'b1, 32'hA007_A006, 5, 4, 0, 4);
        xfer(32'h2000_0000, 1'b0, 3'b010, 2'b10, 3'b011, 32'h0, 4'h0);
        xfer(32'h2000_0004, 1'b0, 3'b010, 2'b11, 3'b011, 32'h0, 4'h0);
        xfer(32'h2000_0008, 1'b0, 3'b010, 2'b11, 3'b011, 32'h0, 4'h0);
        xfer(32'h2000_000C, 1'b0, 3'b010, 2'b11, 3'b011, 32'h0, 4'h0);
        drain();

        check("final_ce_n", 32'(SRAM_CE_N), 32'd1);
        check("final_dq_oe", 32'(SRAM_DQ_OE), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
